// File: rtl/result_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : result_buffer_pkg
//  Purpose  : Shared constants for the ALU result buffer and its controller:
//             default sizing, entry width and the 3-bit ALU op encodings.
//  Revision : 1.0 - initial release
// ============================================================================
package result_buffer_pkg;

  localparam int c_data_w_default = 8;
  localparam int c_depth_default  = 4;

  // Entry layout, MSB first: {op[2:0], carry, zero, data[DATA_W-1:0]}
  localparam int c_op_w     = 3;
  localparam int c_flag_w   = 2;

  function automatic int entry_width(input int data_w);
    return c_op_w + c_flag_w + data_w;
  endfunction

  localparam int c_entry_w_default = c_op_w + c_flag_w + c_data_w_default;

  // ALU operation codes shared with the controller
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_PASS = 3'd7
  } alu_op_e;

endpackage
`default_nettype wire

// File: rtl/result_buffer_mem.sv
`default_nettype none
// ============================================================================
//  Module   : result_buffer_mem
//  Purpose  : DEPTH x ENTRY_W register array, one synchronous write port and
//             one asynchronous read port. The array itself is not reset.
//  Ports    : clk    - clock
//             we     - write enable
//             waddr  - write address
//             wdata  - write data
//             raddr  - read address
//             rdata  - read data (combinational from the array)
//  Revision : 1.0 - initial release
// ============================================================================
module result_buffer_mem
  import result_buffer_pkg::*;
#(
  parameter int DEPTH   = c_depth_default,
  parameter int ENTRY_W = c_entry_w_default
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [ENTRY_W-1:0]       wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [ENTRY_W-1:0]       rdata
);

  logic [ENTRY_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/result_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : result_buffer
//  Purpose  : FIFO of ALU results {op, carry, zero, data} between the ALU
//             controller and a downstream consumer, with a sticky overflow
//             flag recording dropped results.
//  Ports    : clk, rst_n            - clock, async active-low reset
//             result_valid          - one-cycle result pulse
//             result_data/alu_op/zero_flag/carry_flag - result payload
//             out_ready             - consumer accepts head entry
//             ovf_clr               - clear sticky overflow
//             out_valid             - head entry present
//             out_data/out_op/out_zero/out_carry - head entry
//             full, level           - occupancy
//             overflow              - sticky drop indicator
//  Revision : 1.0 - initial release
// ============================================================================
module result_buffer
  import result_buffer_pkg::*;
#(
  parameter int DATA_W = c_data_w_default,
  parameter int DEPTH  = c_depth_default
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   result_valid,
  input  logic [DATA_W-1:0]      result_data,
  input  logic [2:0]             alu_op,
  input  logic                   zero_flag,
  input  logic                   carry_flag,
  input  logic                   out_ready,
  input  logic                   ovf_clr,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [2:0]             out_op,
  output logic                   out_zero,
  output logic                   out_carry,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int c_ptr_w   = $clog2(DEPTH);
  localparam int c_lvl_w   = c_ptr_w + 1;
  localparam int c_entry_w = entry_width(DATA_W);
  localparam logic [c_lvl_w-1:0] c_full_level = c_lvl_w'(DEPTH);

  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_lvl_w-1:0]   r_level;
  logic                 r_overflow;

  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic [c_entry_w-1:0] w_wr_entry;
  logic [c_entry_w-1:0] w_rd_entry;

  // A pop frees a slot in the same cycle, so a full buffer can still accept
  // a push alongside a pop without dropping.
  assign w_pop  = out_valid & out_ready;
  assign w_push = result_valid & (~full | w_pop);
  assign w_drop = result_valid & full & ~w_pop;

  assign w_wr_entry = {alu_op, carry_flag, zero_flag, result_data};

  result_buffer_mem #(
    .DEPTH   (DEPTH),
    .ENTRY_W (c_entry_w)
  ) u_mem (
    .clk   (clk),
    .we    (w_push),
    .waddr (r_wr_ptr),
    .wdata (w_wr_entry),
    .raddr (r_rd_ptr),
    .rdata (w_rd_entry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      // Pointers wrap naturally: DEPTH is a power of two.
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_lvl_w'(1);
        2'b01:   r_level <= r_level - c_lvl_w'(1);
        default: r_level <= r_level;
      endcase

      // A drop in the same cycle as a clear takes priority.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign level     = r_level;
  assign full      = (r_level == c_full_level);
  assign out_valid = (r_level != '0);
  assign overflow  = r_overflow;

  assign out_op    = w_rd_entry[c_entry_w-1 -: 3];
  assign out_carry = w_rd_entry[DATA_W+1];
  assign out_zero  = w_rd_entry[DATA_W];
  assign out_data  = w_rd_entry[DATA_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_result_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_result_buffer
//  Purpose  : Directed self-checking bench for result_buffer (DATA_W=8,
//             DEPTH=4).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_result_buffer;

  logic       clk;
  logic       rst_n;
  logic       result_valid;
  logic [7:0] result_data;
  logic [2:0] alu_op;
  logic       zero_flag;
  logic       carry_flag;
  logic       out_ready;
  logic       ovf_clr;
  logic       out_valid;
  logic [7:0] out_data;
  logic [2:0] out_op;
  logic       out_zero;
  logic       out_carry;
  logic       full;
  logic [2:0] level;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  result_buffer #(
    .DATA_W (8),
    .DEPTH  (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .result_valid (result_valid),
    .result_data  (result_data),
    .alu_op       (alu_op),
    .zero_flag    (zero_flag),
    .carry_flag   (carry_flag),
    .out_ready    (out_ready),
    .ovf_clr      (ovf_clr),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_op       (out_op),
    .out_zero     (out_zero),
    .out_carry    (out_carry),
    .full         (full),
    .level        (level),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: present one result for a single edge.
  task automatic push(input logic [7:0] d, input logic [2:0] op,
                      input logic z, input logic c, input logic rdy);
    result_valid = 1'b1;
    result_data  = d;
    alu_op       = op;
    zero_flag    = z;
    carry_flag   = c;
    out_ready    = rdy;
    tick();
    result_valid = 1'b0;
    out_ready    = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; result_valid = 1'b0; result_data = '0; alu_op = '0;
    zero_flag = 1'b0; carry_flag = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    #12;
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", level); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", full); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    push(8'h5A, 3'd3, 1'b0, 1'b1, 1'b0);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", out_valid); end
    n_checks++; if (out_data !== 8'h5A) begin n_fail++; $display("FAIL single_data got %h exp 5a", out_data); end
    n_checks++; if (out_op !== 3'd3) begin n_fail++; $display("FAIL single_op got %0d exp 3", out_op); end
    n_checks++; if (out_carry !== 1'b1) begin n_fail++; $display("FAIL single_carry got %b exp 1", out_carry); end
    n_checks++; if (out_zero !== 1'b0) begin n_fail++; $display("FAIL single_zero got %b exp 0", out_zero); end
    n_checks++; if (level !== 3'd1) begin n_fail++; $display("FAIL single_level got %0d exp 1", level); end
    tick();
    n_checks++; if (out_data !== 8'h5A) begin n_fail++; $display("FAIL single_hold got %h exp 5a", out_data); end
    pop_one();
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL single_pop_level got %0d exp 0", level); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop_valid got %b exp 0", out_valid); end
    // out_ready while empty does nothing
    pop_one();
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL empty_pop_level got %0d exp 0", level); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 4; i++) push(8'(i), 3'(i), 1'b0, 1'b0, 1'b0);
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %b exp 1", full); end
    n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL fill_level got %0d exp 4", level); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_no_ovf got %b exp 0", overflow); end
    push(8'h05, 3'd5, 1'b1, 1'b1, 1'b0);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL drop_ovf got %b exp 1", overflow); end
    n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL drop_level got %0d exp 4", level); end
    for (int i = 1; i <= 4; i++) begin
      n_checks++; if (out_data !== 8'(i)) begin n_fail++; $display("FAIL drain_data[%0d] got %h exp %h", i, out_data, 8'(i)); end
      n_checks++; if (out_op !== 3'(i)) begin n_fail++; $display("FAIL drain_op[%0d] got %0d exp %0d", i, out_op, 3'(i)); end
      pop_one();
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %b exp 0", out_valid); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
  endtask

  task automatic test_ovf_clr();
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got %b exp 0", overflow); end
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i), 3'd0, 1'b0, 1'b0, 1'b0);
    ovf_clr = 1'b1;
    push(8'hEE, 3'd0, 1'b0, 1'b0, 1'b0);
    ovf_clr = 1'b0;
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_clr_vs_drop got %b exp 1", overflow); end
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr2 got %b exp 0", overflow); end
    for (int i = 0; i < 4; i++) pop_one();
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL ovf_drain_level got %0d exp 0", level); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 1; i <= 4; i++) push(8'(i), 3'd1, 1'b0, 1'b0, 1'b0);
    push(8'h09, 3'd2, 1'b0, 1'b0, 1'b1);
    n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL fullpp_level got %0d exp 4", level); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fullpp_ovf got %b exp 0", overflow); end
    begin
      logic [7:0] exp_q [4];
      exp_q[0] = 8'h02; exp_q[1] = 8'h03; exp_q[2] = 8'h04; exp_q[3] = 8'h09;
      for (int i = 0; i < 4; i++) begin
        n_checks++; if (out_data !== exp_q[i]) begin n_fail++; $display("FAIL fullpp_drain[%0d] got %h exp %h", i, out_data, exp_q[i]); end
        pop_one();
      end
    end
  endtask

  task automatic test_empty_push_pop();
    push(8'h33, 3'd4, 1'b1, 1'b0, 1'b1);
    n_checks++; if (level !== 3'd1) begin n_fail++; $display("FAIL emptypp_level got %0d exp 1", level); end
    n_checks++; if (out_data !== 8'h33) begin n_fail++; $display("FAIL emptypp_data got %h exp 33", out_data); end
    n_checks++; if (out_zero !== 1'b1) begin n_fail++; $display("FAIL emptypp_zero got %b exp 1", out_zero); end
    pop_one();
  endtask

  task automatic test_wrap();
    push(8'h10, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) begin
      n_checks++; if (out_data !== 8'h10 + 8'(i - 1)) begin n_fail++; $display("FAIL wrap_data[%0d] got %h exp %h", i, out_data, 8'h10 + 8'(i - 1)); end
      push(8'h10 + 8'(i), 3'd0, 1'b0, 1'b0, 1'b1);
      n_checks++; if (level !== 3'd1) begin n_fail++; $display("FAIL wrap_level[%0d] got %0d exp 1", i, level); end
    end
    n_checks++; if (out_data !== 8'h19) begin n_fail++; $display("FAIL wrap_last got %h exp 19", out_data); end
    pop_one();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) push(8'hC0 + 8'(i), 3'd0, 1'b0, 1'b0, 1'b0);
    push(8'hFF, 3'd0, 1'b0, 1'b0, 1'b0);
    push(8'hFE, 3'd0, 1'b0, 1'b0, 1'b0);
    pop_one();
    n_checks++; if (level !== 3'd3) begin n_fail++; $display("FAIL mid_pre_level got %0d exp 3", level); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL mid_pre_ovf got %b exp 1", overflow); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL mid_level got %0d exp 0", level); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b exp 0", out_valid); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL mid_full got %b exp 0", full); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_ovf got %b exp 0", overflow); end
    tick();
    rst_n = 1'b1;
    push(8'h77, 3'd6, 1'b0, 1'b0, 1'b0);
    n_checks++; if (out_data !== 8'h77) begin n_fail++; $display("FAIL mid_push_data got %h exp 77", out_data); end
    n_checks++; if (level !== 3'd1) begin n_fail++; $display("FAIL mid_push_level got %0d exp 1", level); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_ovf_clr();
    test_full_push_pop();
    test_empty_push_pop();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
